cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the CPU core.
- Sequences fetch, decode, execute, writeback, memory access and branch for each 16-bit instruction held in the IR.
- Consumes the instruction decoder outputs (op, immed, register fields) plus the raw opcode class bits, and drives PC, IR, register file, ALU and memory-port strobes.
- Owns the condition flag written by compare instructions and consumed by BR.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- MEM_TIMEOUT, 0, cycles to wait for mem_ready before flagging a bus error; 0 disables the timeout

Ports:
- CLK  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  pulse; leaves IDLE and begins fetching at current PC
- halt_req  input  1  level; return to IDLE at the next instruction boundary
- op_class  input  5  IR[4:0], instruction class
- immed  input  1  decoder: operand B is the immediate
- alu_flag  input  1  ALU result bit 0, valid in EXEC
- mem_ready  input  1  memory completion pulse for the outstanding request
- ir_load  output  1  load IR from memory read data
- pc_inc  output  1  PC <= PC+1
- pc_load  output  1  PC <= branch target
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  1 = store, 0 = load/fetch; valid while mem_req=1
- mem_addr_sel  output  1  0 = PC, 1 = register rA
- alu_en  output  1  ALU evaluate/latch result
- alu_src_imm  output  1  selects immediate as operand B
- rf_we  output  1  register-file write to rOut
- rf_wsel  output  1  0 = ALU result, 1 = memory read data
- cond_flag  output  1  last compare result
- busy  output  1  1 in any state except IDLE
- illegal  output  1  sticky; unknown class seen
- bus_err  output  1  sticky; memory timeout
- retired  output  CNT_W  retired-instruction count, wraps

Behaviour:
- Reset (asynchronous): state=IDLE. cond_flag, illegal, bus_err and retired are cleared. All strobes are 0. An outstanding mem_req drops immediately.
- States: IDLE, FETCH, DECODE, EXEC, WB, BRANCH, MEM.
- Output style: strobes are Moore, decoded from state, except ir_load and the load-path rf_we. Those two are Mealy, asserted in the cycle mem_ready=1.
- IDLE: start=1 -> FETCH. Otherwise stay.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. On mem_ready: ir_load=1 and go to DECODE.
- DECODE: one cycle, pc_inc=1. Transition by op_class:
  - 0x00-0x0F -> EXEC
  - 0x10 -> EXEC
  - 0x11 -> BRANCH
  - 0x12, 0x13 -> MEM
  - 0x14-0x1F -> set illegal, retire as NOP, take the boundary rule
- EXEC: alu_en=1, alu_src_imm=immed. Go to WB.
- WB: rf_we=1, rf_wsel=0. For classes 0x0E/0x0F/0x10 (compares), cond_flag <= alu_flag captured in EXEC and the result is also written to rOut. Then take the boundary rule.
- BRANCH: pc_load=cond_flag. Then take the boundary rule. Branch target computation is outside this block.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we = (class==0x12).
  - On mem_ready: for a load, rf_we=1 and rf_wsel=1 in that same cycle. Then take the boundary rule.
- Boundary rule: retired increments (wrapping at 2^CNT_W). Next state is IDLE if halt_req=1, else FETCH.
- mem_ready while mem_req=0 is ignored.
- mem_req, mem_we and mem_addr_sel stay stable until mem_ready arrives.
- Timeout: if MEM_TIMEOUT>0 and mem_req has been held for MEM_TIMEOUT cycles without mem_ready, set bus_err and go to IDLE.
- start while busy is ignored. halt_req is sampled only at boundaries.
- Cycle counts, with zero memory wait (mem_ready in the first request cycle):
  - ALU/compare: 4
  - BR: 3
  - STW/LDW: 3
  - Each memory wait cycle adds 1.

Decomposition:
- Shared package cpu_pkg:
  - opcode class constants (ADD..LDW, 5-bit)
  - ALU op codes (IDLE..EQ, 4-bit)
  - state encoding localparams
- The decoder and this sequencer both import the package.
- Single module; no sub-module is needed. The optional timeout counter stays inline.

Test Plan:
- Reset mid-FETCH with mem_req=1 -> mem_req=0 asynchronously, state IDLE, retired=0.
- start, then ADD (class 0x00) with mem_ready in cycle 1 -> ir_load at cycle 1, pc_inc at 2, alu_en at 3, rf_we at 4 (rf_wsel=0), retired=1, back in FETCH.
- ADDI (0x07) -> alu_src_imm=1 during EXEC. Then EQ (0x10) with alu_flag=1, then BR (0x11) -> cond_flag=1 and pc_load=1 in BRANCH.
- LDW (0x13) with mem_ready delayed 3 cycles -> mem_req/mem_addr_sel=1 held 4 cycles with mem_we=0; rf_we=1 and rf_wsel=1 only in the ready cycle. STW (0x12) -> mem_we=1, rf_we never asserted.
- Class 0x15 -> illegal=1 stays set, no rf_we or mem_req for that instruction, and the next fetch proceeds.
- halt_req=1 during EXEC -> IDLE after WB, busy=0. With MEM_TIMEOUT=8 and no mem_ready -> bus_err=1 after 8 request cycles, then IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core: opcode classes, ALU op codes and
// the sequencer state encoding.
package cpu_pkg;

  // Instruction classes carried in IR[4:0]
  localparam logic [4:0] CLS_ADD  = 5'h00;
  localparam logic [4:0] CLS_SUB  = 5'h01;
  localparam logic [4:0] CLS_AND  = 5'h02;
  localparam logic [4:0] CLS_OR   = 5'h03;
  localparam logic [4:0] CLS_XOR  = 5'h04;
  localparam logic [4:0] CLS_NOT  = 5'h05;
  localparam logic [4:0] CLS_SHL  = 5'h06;
  localparam logic [4:0] CLS_ADDI = 5'h07;
  localparam logic [4:0] CLS_SUBI = 5'h08;
  localparam logic [4:0] CLS_ANDI = 5'h09;
  localparam logic [4:0] CLS_ORI  = 5'h0A;
  localparam logic [4:0] CLS_XORI = 5'h0B;
  localparam logic [4:0] CLS_SHR  = 5'h0C;
  localparam logic [4:0] CLS_MOV  = 5'h0D;
  localparam logic [4:0] CLS_LT   = 5'h0E;
  localparam logic [4:0] CLS_GT   = 5'h0F;
  localparam logic [4:0] CLS_EQ   = 5'h10;
  localparam logic [4:0] CLS_BR   = 5'h11;
  localparam logic [4:0] CLS_STW  = 5'h12;
  localparam logic [4:0] CLS_LDW  = 5'h13;

  // ALU operation codes produced by the instruction decoder
  typedef enum logic [3:0] {
    ALU_IDLE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOT  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_SHR  = 4'd8,
    ALU_MOV  = 4'd9,
    ALU_LT   = 4'd10,
    ALU_GT   = 4'd11,
    ALU_EQ   = 4'd12
  } alu_op_e;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_FETCH_ENC  = 3'd1;
  localparam logic [2:0] ST_DECODE_ENC = 3'd2;
  localparam logic [2:0] ST_EXEC_ENC   = 3'd3;
  localparam logic [2:0] ST_WB_ENC     = 3'd4;
  localparam logic [2:0] ST_BRANCH_ENC = 3'd5;
  localparam logic [2:0] ST_MEM_ENC    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_FETCH  = ST_FETCH_ENC,
    ST_DECODE = ST_DECODE_ENC,
    ST_EXEC   = ST_EXEC_ENC,
    ST_WB     = ST_WB_ENC,
    ST_BRANCH = ST_BRANCH_ENC,
    ST_MEM    = ST_MEM_ENC
  } seq_state_e;

  // Compare classes update the condition flag in addition to writing rOut
  function automatic logic is_compare(input logic [4:0] cls);
    return (cls == CLS_LT) || (cls == CLS_GT) || (cls == CLS_EQ);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch / decode / execute / writeback / memory /
// branch sequencing for one 16-bit instruction at a time.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | stopped; waits for start
// FETCH  | instruction read at PC; IR loads on mem_ready
// DECODE | PC increments; dispatch on instruction class
// EXEC   | ALU evaluates, operand B optionally immediate
// WB     | ALU result written to rOut; compares also update cond_flag
// BRANCH | PC loads branch target when cond_flag is set
// MEM    | load/store at address rA; loads write rOut on mem_ready
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [4:0]       op_class,
  input  logic             immed,
  input  logic             alu_flag,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             alu_en,
  output logic             alu_src_imm,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic             cond_flag,
  output logic             busy,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  // Timeout down-counter is reloaded with MEM_TIMEOUT-1 and expires at zero,
  // so the request is abandoned in its MEM_TIMEOUT-th unanswered cycle.
  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD =
    (MEM_TIMEOUT > 0) ? TMO_W'(MEM_TIMEOUT - 1) : '0;

  seq_state_e       state_q, state_d;
  logic [4:0]       cls_q;
  logic             flag_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             boundary;
  logic             timeout;
  logic             set_illegal;
  logic             write_cond;

  assign busy    = (state_q != ST_IDLE);
  assign tmo_hit = (MEM_TIMEOUT > 0) && (tmo_cnt == '0);

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and strobe decode
  always_comb begin
    state_d      = state_q;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_en       = 1'b0;
    alu_src_imm  = 1'b0;
    rf_we        = 1'b0;
    rf_wsel      = 1'b0;
    boundary     = 1'b0;
    timeout      = 1'b0;
    set_illegal  = 1'b0;
    write_cond   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        pc_inc = 1'b1;
        if (op_class <= CLS_EQ) begin
          state_d = ST_EXEC;
        end else if (op_class == CLS_BR) begin
          state_d = ST_BRANCH;
        end else if ((op_class == CLS_STW) || (op_class == CLS_LDW)) begin
          state_d = ST_MEM;
        end else begin
          // Unknown class retires as a NOP
          set_illegal = 1'b1;
          boundary    = 1'b1;
        end
      end
      ST_EXEC: begin
        alu_en      = 1'b1;
        alu_src_imm = immed;
        state_d     = ST_WB;
      end
      ST_WB: begin
        rf_we      = 1'b1;
        write_cond = is_compare(cls_q);
        boundary   = 1'b1;
      end
      ST_BRANCH: begin
        pc_load  = cond_flag;
        boundary = 1'b1;
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CLS_STW);
        if (mem_ready) begin
          if (cls_q == CLS_LDW) begin
            rf_we   = 1'b1;
            rf_wsel = 1'b1;
          end
          boundary = 1'b1;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (boundary) state_d = halt_req ? ST_IDLE : ST_FETCH;
  end

  // Class is held from DECODE so MEM/WB decode stays stable; ALU flag is
  // captured in EXEC for the compare writeback.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cls_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      if (state_q == ST_DECODE) cls_q  <= op_class;
      if (state_q == ST_EXEC)   flag_q <= alu_flag;
    end
  end

  // Memory wait timeout counter, reloaded whenever no request is pending
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                     tmo_cnt <= TMO_LOAD;
    else if (!mem_req || mem_ready) tmo_cnt <= TMO_LOAD;
    else if (tmo_cnt != '0)        tmo_cnt <= tmo_cnt - 1'b1;
  end

  // Condition flag, sticky error flags and retired-instruction counter
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cond_flag <= 1'b0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
      retired   <= '0;
    end else begin
      if (write_cond)  cond_flag <= flag_q;
      if (set_illegal) illegal   <= 1'b1;
      if (timeout)     bus_err   <= 1'b1;
      if (boundary)    retired   <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction-by-instruction strobe checks.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic        start, halt_req, immed, alu_flag, mem_ready;
  logic [4:0]  op_class;
  logic        ir_load, pc_inc, pc_load, mem_req, mem_we, mem_addr_sel;
  logic        alu_en, alu_src_imm, rf_we, rf_wsel;
  logic        cond_flag, busy, illegal, bus_err;
  logic [15:0] retired;
  logic [9:0]  strb;

  int tests = 0;
  int fails = 0;

  localparam logic [9:0] S_NONE = 10'b0000000000;
  localparam logic [9:0] S_IRL  = 10'b1000000000;
  localparam logic [9:0] S_PCI  = 10'b0100000000;
  localparam logic [9:0] S_PCL  = 10'b0010000000;
  localparam logic [9:0] S_REQ  = 10'b0001000000;
  localparam logic [9:0] S_WE   = 10'b0000100000;
  localparam logic [9:0] S_ASEL = 10'b0000010000;
  localparam logic [9:0] S_ALU  = 10'b0000001000;
  localparam logic [9:0] S_IMM  = 10'b0000000100;
  localparam logic [9:0] S_RFW  = 10'b0000000010;
  localparam logic [9:0] S_RFS  = 10'b0000000001;

  cpu_sequencer #(.CNT_W(16), .MEM_TIMEOUT(8)) dut (
    .CLK(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .op_class(op_class), .immed(immed), .alu_flag(alu_flag),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .alu_en(alu_en), .alu_src_imm(alu_src_imm),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .cond_flag(cond_flag), .busy(busy),
    .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  assign strb = {ir_load, pc_inc, pc_load, mem_req, mem_we, mem_addr_sel,
                 alu_en, alu_src_imm, rf_we, rf_wsel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [4:0] cls);
    op_class  = cls;
    mem_ready = 1'b1;
    #1 chk("fetch_strb", strb, S_IRL | S_REQ);
    cyc();
    mem_ready = 1'b0;
  endtask

  task automatic decode();
    #1 chk("decode_strb", strb, S_PCI);
    cyc();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; immed = 1'b0;
    alu_flag = 1'b0; mem_ready = 1'b0; op_class = 5'h00;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_strb", strb, S_NONE);
    chk("rst_busy", busy, 0);
    chk("rst_retired", retired, 0);
    chk("rst_flags", {cond_flag, illegal, bus_err}, 3'b000);

    // mem_ready with no request outstanding is ignored
    mem_ready = 1'b1;
    #1 chk("idle_ready_strb", strb, S_NONE);
    cyc();
    mem_ready = 1'b0;
    #1 chk("idle_ready_busy", busy, 0);

    // ADD: ir_load c1, pc_inc c2, alu_en c3, rf_we c4
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", busy, 1);
    fetch(5'h00);
    decode();
    alu_flag = 1'b1;
    #1 chk("add_exec", strb, S_ALU);
    cyc();
    alu_flag = 1'b0;
    #1 chk("add_wb", strb, S_RFW);
    cyc();
    #1 chk("add_retired", retired, 1);
    chk("add_cond_kept", cond_flag, 0);
    chk("add_back_fetch", strb, S_REQ);

    // ADDI: immediate operand in EXEC
    fetch(5'h07);
    decode();
    immed = 1'b1;
    #1 chk("addi_exec", strb, S_ALU | S_IMM);
    cyc();
    immed = 1'b0;
    #1 chk("addi_wb", strb, S_RFW);
    cyc();

    // EQ with alu_flag=1 sets cond_flag
    fetch(5'h10);
    decode();
    alu_flag = 1'b1;
    #1 chk("eq_exec", strb, S_ALU);
    cyc();
    alu_flag = 1'b0;
    #1 chk("eq_wb", strb, S_RFW);
    cyc();
    #1 chk("eq_cond", cond_flag, 1);
    chk("eq_retired", retired, 3);

    // BR with cond_flag=1 loads PC
    fetch(5'h11);
    decode();
    #1 chk("br_branch", strb, S_PCL);
    cyc();
    #1 chk("br_retired", retired, 4);

    // LDW with three wait cycles
    fetch(5'h13);
    decode();
    for (int i = 0; i < 3; i++) begin
      #1 chk("ldw_wait", strb, S_REQ | S_ASEL);
      cyc();
    end
    mem_ready = 1'b1;
    #1 chk("ldw_ready", strb, S_REQ | S_ASEL | S_RFW | S_RFS);
    cyc();
    mem_ready = 1'b0;
    #1 chk("ldw_retired", retired, 5);

    // STW with zero wait
    fetch(5'h12);
    decode();
    mem_ready = 1'b1;
    #1 chk("stw_ready", strb, S_REQ | S_WE | S_ASEL);
    cyc();
    mem_ready = 1'b0;
    #1 chk("stw_retired", retired, 6);

    // Illegal class retires as NOP, next fetch proceeds
    fetch(5'h15);
    decode();
    #1 chk("ill_flag", illegal, 1);
    chk("ill_retired", retired, 7);
    chk("ill_next_fetch", strb, S_REQ);

    // ADD with halt requested during EXEC: IDLE after WB
    fetch(5'h00);
    decode();
    halt_req = 1'b1;
    #1 chk("halt_exec", strb, S_ALU);
    cyc();
    #1 chk("halt_wb", strb, S_RFW);
    cyc();
    halt_req = 1'b0;
    #1 chk("halt_busy", busy, 0);
    chk("halt_strb", strb, S_NONE);
    chk("halt_retired", retired, 8);
    chk("ill_sticky", illegal, 1);

    // Asynchronous reset during FETCH drops mem_req at once
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1 chk("pre_rst_req", mem_req, 1);
    reset = 1'b1;
    #1 chk("async_rst_req", mem_req, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_retired", retired, 0);
    chk("async_rst_flags", {cond_flag, illegal}, 2'b00);
    reset = 1'b0;
    cyc();

    // Timeout after 8 unanswered fetch cycles
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 chk("tmo_req", {strb, bus_err}, {S_REQ, 1'b0});
      cyc();
    end
    #1 chk("tmo_bus_err", bus_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_strb", strb, S_NONE);
    cyc();
    #1 chk("tmo_sticky", bus_err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
